// File: rtl/elevator_pkg.sv
// Shared elevator constants and types.
// Floor count, index width and travel direction encoding.
package elevator_pkg;

    localparam int FLOORS  = 4;
    localparam int FLOOR_W = 2;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/floor_request_latch_rise_detect.sv
// Vectorised rising-edge detector for debounced button levels.
// A press is one cycle wide; a held or released button yields nothing.
module rise_detect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] press
);

    logic [W-1:0] level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/floor_request_latch.sv
// Latches floor button presses as pending requests until served,
// and picks the next target floor for the current travel direction.
module floor_request_latch
    import elevator_pkg::*;
#(
    parameter int FLOORS  = elevator_pkg::FLOORS,
    parameter int FLOOR_W = elevator_pkg::FLOOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  btn,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               dir,
    input  logic               serve,
    output logic [FLOORS-1:0]  req,
    output logic               new_req,
    output logic               any_req,
    output logic               req_here,
    output logic               req_above,
    output logic               req_below,
    output logic [FLOOR_W-1:0] next_floor,
    output logic               next_valid
);

    logic [FLOORS-1:0] press;
    logic [FLOORS-1:0] clr;
    logic [FLOORS-1:0] req_nxt;
    logic [FLOOR_W:0]  above;
    logic [FLOOR_W:0]  below;

    // Lowest set index strictly above c; MSB flags a hit.
    function automatic logic [FLOOR_W:0] scan_above(
        input logic [FLOORS-1:0]  r,
        input logic [FLOOR_W-1:0] c
    );
        logic [FLOOR_W:0] res;
        res = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (r[i] && (FLOOR_W'(i) > c)) begin
                res = {1'b1, FLOOR_W'(i)};
            end
        end
        return res;
    endfunction

    // Highest set index strictly below c; MSB flags a hit.
    function automatic logic [FLOOR_W:0] scan_below(
        input logic [FLOORS-1:0]  r,
        input logic [FLOOR_W-1:0] c
    );
        logic [FLOOR_W:0] res;
        res = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (r[i] && (FLOOR_W'(i) < c)) begin
                res = {1'b1, FLOOR_W'(i)};
            end
        end
        return res;
    endfunction

    rise_detect #(
        .W(FLOORS)
    ) u_rise (
        .clk  (clk),
        .rst  (rst),
        .level(btn),
        .press(press)
    );

    always_comb begin
        clr = '0;
        for (int i = 0; i < FLOORS; i++) begin
            clr[i] = serve && (FLOOR_W'(i) == cur_floor);
        end
    end

    // Clear beats a same-cycle press at the served floor.
    assign req_nxt = (req | press) & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req     <= '0;
            new_req <= 1'b0;
        end else begin
            req     <= req_nxt;
            new_req <= |(req_nxt & ~req);
        end
    end

    always_comb begin
        req_here = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (req[i] && (FLOOR_W'(i) == cur_floor)) begin
                req_here = 1'b1;
            end
        end
    end

    assign above     = scan_above(req, cur_floor);
    assign below     = scan_below(req, cur_floor);
    assign any_req   = |req;
    assign req_above = above[FLOOR_W];
    assign req_below = below[FLOOR_W];
    assign next_valid = any_req;

    always_comb begin
        next_floor = cur_floor;
        if (req_here) begin
            next_floor = cur_floor;
        end else if (dir == DIR_UP) begin
            if (req_above) begin
                next_floor = above[FLOOR_W-1:0];
            end else if (req_below) begin
                next_floor = below[FLOOR_W-1:0];
            end
        end else begin
            if (req_below) begin
                next_floor = below[FLOOR_W-1:0];
            end else if (req_above) begin
                next_floor = above[FLOOR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_floor_request_latch.sv
// Directed bench for floor_request_latch with a behavioural model.
// Model state is checked every falling edge; literals pin key cases.
module tb_floor_request_latch;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] cur_floor;
    logic       dir;
    logic       serve;
    logic [3:0] req;
    logic       new_req;
    logic       any_req;
    logic       req_here;
    logic       req_above;
    logic       req_below;
    logic [1:0] next_floor;
    logic       next_valid;

    int checks;
    int failures;

    floor_request_latch dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .cur_floor (cur_floor),
        .dir       (dir),
        .serve     (serve),
        .req       (req),
        .new_req   (new_req),
        .any_req   (any_req),
        .req_here  (req_here),
        .req_above (req_above),
        .req_below (req_below),
        .next_floor(next_floor),
        .next_valid(next_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending floors plus last button levels.
    bit [3:0] m_req;
    bit [3:0] m_prev;
    bit       m_new;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req  <= 4'b0;
            m_prev <= 4'b0;
            m_new  <= 1'b0;
        end else begin
            bit [3:0] nxt;
            nxt = m_req;
            for (int f = 0; f < 4; f++) begin
                if (btn[f] && !m_prev[f]) nxt[f] = 1'b1;
                if (serve && int'(cur_floor) == f) nxt[f] = 1'b0;
            end
            m_new  <= (nxt & ~m_req) != 4'b0;
            m_req  <= nxt;
            m_prev <= btn;
        end
    end

    function automatic int nearest_up(bit [3:0] r, int cur);
        int best;
        best = -1;
        for (int f = 0; f < 4; f++)
            if (r[f] && f > cur && (best < 0 || f < best)) best = f;
        return best;
    endfunction

    function automatic int nearest_dn(bit [3:0] r, int cur);
        int best;
        best = -1;
        for (int f = 0; f < 4; f++)
            if (r[f] && f < cur && f > best) best = f;
        return best;
    endfunction

    function automatic int exp_next(bit [3:0] r, int cur, bit d);
        int up;
        int dn;
        up = nearest_up(r, cur);
        dn = nearest_dn(r, cur);
        if (cur < 4 && r[cur]) return cur;
        if (d == 1'b0) begin
            if (up >= 0) return up;
            if (dn >= 0) return dn;
        end else begin
            if (dn >= 0) return dn;
            if (up >= 0) return up;
        end
        return cur;
    endfunction

    always @(negedge clk) begin
        int c;
        c = int'(cur_floor);
        chk("m_req", int'(req), int'(m_req));
        chk("m_new_req", int'(new_req), int'(m_new));
        chk("m_any_req", int'(any_req), int'(m_req != 0));
        chk("m_next_valid", int'(next_valid), int'(m_req != 0));
        chk("m_req_here", int'(req_here), int'(m_req[c]));
        chk("m_req_above", int'(req_above), int'(nearest_up(m_req, c) >= 0));
        chk("m_req_below", int'(req_below), int'(nearest_dn(m_req, c) >= 0));
        chk("m_next_floor", int'(next_floor), exp_next(m_req, c, dir));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0] b;
        logic [1:0] c;
        logic       d;
        logic       s;
    } vec_t;

    vec_t vecs[8];
    int   pulses;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        btn       = 4'b0;
        cur_floor = 2'd0;
        dir       = 1'b0;
        serve     = 1'b0;
        #12;
        chk("rst_req", int'(req), 0);
        chk("rst_new_req", int'(new_req), 0);
        chk("rst_any_req", int'(any_req), 0);
        chk("rst_next_floor", int'(next_floor), 0);
        rst = 1'b0;
        step();

        // Held button: one latch, one pulse.
        btn = 4'b0100;
        step();
        chk("hold_req", int'(req), 4'b0100);
        chk("hold_new_req", int'(new_req), 1);
        step();
        chk("hold_pulse_gone", int'(new_req), 0);
        pulses = 0;
        repeat (8) begin
            step();
            if (new_req) pulses++;
        end
        chk("hold_no_more_pulses", pulses, 0);

        // Build req = 1010 while serving floor 2.
        btn = 4'b1010;
        cur_floor = 2'd2;
        serve = 1'b1;
        step();
        btn = 4'b0;
        serve = 1'b0;
        dir = 1'b0;
        #1;
        chk("sel_req_1010", int'(req), 4'b1010);
        chk("sel_up_next", int'(next_floor), 3);
        chk("sel_up_above", int'(req_above), 1);
        chk("sel_up_below", int'(req_below), 1);
        dir = 1'b1;
        #1;
        chk("sel_dn_next", int'(next_floor), 1);

        // Reduce to req = 0001; up-direction falls back to below.
        cur_floor = 2'd1;
        serve = 1'b1;
        btn = 4'b0001;
        step();
        cur_floor = 2'd3;
        btn = 4'b0;
        step();
        serve = 1'b0;
        cur_floor = 2'd2;
        dir = 1'b0;
        #1;
        chk("fallback_req", int'(req), 4'b0001);
        chk("fallback_next", int'(next_floor), 0);

        // Press and serve on the same floor: press dropped.
        cur_floor = 2'd1;
        serve = 1'b1;
        btn = 4'b0010;
        step();
        chk("clr_wins_req1", int'(req[1]), 0);
        chk("clr_wins_new_req", int'(new_req), 0);
        serve = 1'b0;
        btn = 4'b0;
        step();

        // Async reset mid-cycle, then re-register a held button.
        btn = 4'b1111;
        step();
        chk("all_req", int'(req), 4'b1111);
        btn = 4'b1000;
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req", int'(req), 0);
        chk("async_rst_any", int'(any_req), 0);
        rst = 1'b0;
        step();
        chk("held_rereg_req", int'(req), 4'b1000);
        chk("held_rereg_new", int'(new_req), 1);
        btn = 4'b0;

        // Serve the only request at floor 3.
        cur_floor = 2'd3;
        serve = 1'b1;
        step();
        serve = 1'b0;
        #1;
        chk("serve3_req", int'(req), 0);
        chk("serve3_any", int'(any_req), 0);
        chk("serve3_valid", int'(next_valid), 0);
        chk("serve3_next", int'(next_floor), 3);

        // Mixed vectors checked by the model only.
        vecs[0] = '{4'b0110, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{4'b0000, 2'd3, 1'b1, 1'b0};
        vecs[2] = '{4'b1001, 2'd2, 1'b1, 1'b1};
        vecs[3] = '{4'b1001, 2'd1, 1'b0, 1'b0};
        vecs[4] = '{4'b0000, 2'd0, 1'b1, 1'b1};
        vecs[5] = '{4'b0011, 2'd2, 1'b0, 1'b0};
        vecs[6] = '{4'b0000, 2'd3, 1'b1, 1'b1};
        vecs[7] = '{4'b1100, 2'd1, 1'b0, 1'b0};
        foreach (vecs[i]) begin
            btn       = vecs[i].b;
            cur_floor = vecs[i].c;
            dir       = vecs[i].d;
            serve     = vecs[i].s;
            step();
        end
        serve = 1'b0;
        btn = 4'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
